// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_fifo
//  Brief    : Receive-side byte FIFO behind a UART receiver. Bytes strobed
//             in with rx_ready are read out on a first-word-fall-through
//             valid/ready port. Sticky overflow and framing-error flags are
//             kept alongside.
//             Optional build macro UART_RX_FIFO_ERR_CNT_EN adds an 8-bit
//             saturating framing-error counter on port ferr_count.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic                  rx_ready,
    input  logic [7:0]            rx_data,
    input  logic                  framing_error,
    input  logic                  rd_ready,
    output logic                  rd_valid,
    output logic [7:0]            rd_data,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    output logic                  ferr,
    input  logic                  clr_flags
`ifdef UART_RX_FIFO_ERR_CNT_EN
    ,
    output logic [7:0]            ferr_count
`endif
);

    localparam int c_DEPTH = 1 << DEPTH_LOG2;

    logic [7:0]          r_mem [0:c_DEPTH-1];
    logic [DEPTH_LOG2:0] r_wr_ptr;
    logic [DEPTH_LOG2:0] r_rd_ptr;
    logic                r_overflow;
    logic                r_ferr;
    logic                r_ferr_prev;

    logic                w_full;
    logic                w_empty;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;
    logic                w_ferr_rise;

    // The extra pointer MSB tells a full FIFO from an empty one when the
    // index bits match.
    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_full      = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                         (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);
    assign w_pop       = !w_empty && rd_ready;
    assign w_push      = rx_ready && (!w_full || w_pop);
    assign w_drop      = rx_ready && w_full && !w_pop;
    assign w_ferr_rise = framing_error && !r_ferr_prev;

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= rx_data;
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Clear wins over a same-cycle set, so a coincident event is lost.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_ferr      <= 1'b0;
            r_ferr_prev <= 1'b0;
        end else begin
            r_ferr_prev <= framing_error;
            if (clr_flags) begin
                r_overflow <= 1'b0;
                r_ferr     <= 1'b0;
            end else begin
                if (w_drop)      r_overflow <= 1'b1;
                if (w_ferr_rise) r_ferr     <= 1'b1;
            end
        end
    end

`ifdef UART_RX_FIFO_ERR_CNT_EN
    logic [7:0] r_ferr_count;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_ferr_count <= 8'd0;
        end else if (clr_flags) begin
            r_ferr_count <= 8'd0;
        end else if (w_ferr_rise && (r_ferr_count != 8'hFF)) begin
            r_ferr_count <= r_ferr_count + 8'd1;
        end
    end

    assign ferr_count = r_ferr_count;
`endif

    assign rd_valid = !w_empty;
    assign rd_data  = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
    assign count    = r_wr_ptr - r_rd_ptr;
    assign full     = w_full;
    assign empty    = w_empty;
    assign overflow = r_overflow;
    assign ferr     = r_ferr;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_fifo
//  Brief    : Directed self-checking bench for uart_rx_fifo; expected read
//             bytes are queued at stimulus time and popped by a monitor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    localparam int DEPTH_LOG2 = 4;

    logic                CLK = 1'b0;
    logic                rst;
    logic                rx_ready;
    logic [7:0]          rx_data;
    logic                framing_error;
    logic                rd_ready;
    logic                rd_valid;
    logic [7:0]          rd_data;
    logic [DEPTH_LOG2:0] count;
    logic                full;
    logic                empty;
    logic                overflow;
    logic                ferr;
    logic                clr_flags;
`ifdef UART_RX_FIFO_ERR_CNT_EN
    logic [7:0]          ferr_count;
`endif

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  exp_q[$];

    uart_rx_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .CLK           (CLK),
        .rst           (rst),
        .rx_ready      (rx_ready),
        .rx_data       (rx_data),
        .framing_error (framing_error),
        .rd_ready      (rd_ready),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .count         (count),
        .full          (full),
        .empty         (empty),
        .overflow      (overflow),
        .ferr          (ferr),
        .clr_flags     (clr_flags)
`ifdef UART_RX_FIFO_ERR_CNT_EN
        ,
        .ferr_count    (ferr_count)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: every accepted read must match the head of the expected queue.
    always @(negedge CLK) begin
        if (!rst && rd_valid && rd_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL rd_unexpected: got 0x%0h, expected no byte", rd_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    n_err++;
                    $display("FAIL rd_data: got 0x%0h, expected 0x%0h", rd_data, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        rst = 1'b1; rx_ready = 1'b0; rx_data = 8'h00; framing_error = 1'b0;
        rd_ready = 1'b0; clr_flags = 1'b0;
        #12;
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_empty", 32'(empty), 32'd1);
        chk("reset_full", 32'(full), 32'd0);
        chk("reset_rd_valid", 32'(rd_valid), 32'd0);
        chk("reset_overflow", 32'(overflow), 32'd0);
        chk("reset_ferr", 32'(ferr), 32'd0);
        tick();
        rst = 1'b0;

        // Three single pushes, then drain in order.
        for (int i = 0; i < 3; i++) begin
            rx_ready = 1'b1; rx_data = 8'h41 + 8'(i);
            exp_q.push_back(8'h41 + 8'(i));
            tick();
            chk("t1_rd_valid", 32'(rd_valid), 32'd1);
            chk("t1_count_up", 32'(count), 32'(i + 1));
        end
        rx_ready = 1'b0;
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t1_count_down", 32'(count), 32'(2 - i));
        end
        rd_ready = 1'b0;
        chk("t1_empty", 32'(empty), 32'd1);

        // Fill to full, then one dropped byte.
        for (int i = 0; i < 16; i++) begin
            rx_ready = 1'b1; rx_data = 8'(i);
            exp_q.push_back(8'(i));
            tick();
        end
        chk("t2_count16", 32'(count), 32'd16);
        chk("t2_full", 32'(full), 32'd1);
        chk("t2_ovf_before", 32'(overflow), 32'd0);
        rx_data = 8'hAA;
        tick();
        rx_ready = 1'b0;
        chk("t2_overflow", 32'(overflow), 32'd1);
        chk("t2_count_after_drop", 32'(count), 32'd16);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        chk("t2_ovf_cleared", 32'(overflow), 32'd0);
        chk("t2_count_kept", 32'(count), 32'd16);

        // Full with simultaneous push and pop.
        rx_ready = 1'b1; rx_data = 8'h55; rd_ready = 1'b1;
        exp_q.push_back(8'h55);
        tick();
        rx_ready = 1'b0;
        chk("t3_count16", 32'(count), 32'd16);
        chk("t3_overflow", 32'(overflow), 32'd0);
        for (int i = 0; i < 16; i++) tick();
        rd_ready = 1'b0;
        chk("t3_empty", 32'(empty), 32'd1);
        chk("t3_queue_drained", 32'(exp_q.size()), 32'd0);

        // Two held framing-error levels count as two events.
        for (int k = 0; k < 2; k++) begin
            framing_error = 1'b1;
            for (int i = 0; i < 3; i++) tick();
            framing_error = 1'b0;
            tick(); tick();
        end
        chk("t4_ferr", 32'(ferr), 32'd1);
`ifdef UART_RX_FIFO_ERR_CNT_EN
        chk("t4_ferr_count", 32'(ferr_count), 32'd2);
`endif
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        chk("t4_ferr_cleared", 32'(ferr), 32'd0);
`ifdef UART_RX_FIFO_ERR_CNT_EN
        chk("t4_ferr_count_cleared", 32'(ferr_count), 32'd0);
`endif
        chk("t4_count", 32'(count), 32'd0);

        // 40-byte stream with continuous read: pointers wrap twice.
        rd_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rx_ready = 1'b1; rx_data = 8'h80 + 8'(i);
            exp_q.push_back(8'h80 + 8'(i));
            tick();
        end
        rx_ready = 1'b0;
        tick();
        rd_ready = 1'b0;
        chk("t5_count", 32'(count), 32'd0);
        chk("t5_overflow", 32'(overflow), 32'd0);
        chk("t5_queue_drained", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset mid-stream with five bytes stored.
        framing_error = 1'b1;
        tick();
        framing_error = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rx_ready = 1'b1; rx_data = 8'hC0 + 8'(i);
            tick();
        end
        rx_ready = 1'b0;
        chk("t6_count5", 32'(count), 32'd5);
        chk("t6_ferr_set", 32'(ferr), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_count", 32'(count), 32'd0);
        chk("t6_async_rd_valid", 32'(rd_valid), 32'd0);
        chk("t6_async_overflow", 32'(overflow), 32'd0);
        chk("t6_async_ferr", 32'(ferr), 32'd0);
        tick();
        rst = 1'b0;

        // Normal operation resumes after reset.
        rx_ready = 1'b1; rx_data = 8'h77;
        exp_q.push_back(8'h77);
        tick();
        rx_ready = 1'b0;
        chk("t6_post_count", 32'(count), 32'd1);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        chk("t6_post_empty", 32'(empty), 32'd1);
        chk("t6_post_queue", 32'(exp_q.size()), 32'd0);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
